// File: rtl/image_capture_controller_pkg.sv
// ----------------------------------------------------------------------------
// img_ctrl_pkg: shared state encoding, command bytes and reply constants
// Rev 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package img_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_IMG    = 3'd1,
    ST_START_BNN = 3'd2,
    ST_WAIT_BNN  = 3'd3,
    ST_SEND_RES  = 3'd4,
    ST_CLEAR     = 3'd5,
    ST_ERROR     = 3'd6
  } img_state_e;

  localparam logic [3:0] RESULT_TAG      = 4'hA;
  localparam logic [7:0] ERR_BYTE        = 8'hEE;
  localparam int         DEF_NUM_BYTES   = 113;
  localparam logic [7:0] DEF_CMD_START   = 8'hA5;
  localparam logic [7:0] DEF_CMD_CLEAR   = 8'hC3;

  // States in which an incoming SPI byte is discarded
  function automatic logic is_drop_state(input logic [2:0] s);
    case (s)
      ST_START_BNN, ST_WAIT_BNN, ST_SEND_RES, ST_CLEAR, ST_ERROR: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/image_capture_controller_if.sv
// ----------------------------------------------------------------------------
// image_capture_controller_if: SPI, image-buffer, BNN and reply signal bundle
// Rev 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface image_capture_controller_if;
  logic       spi_byte_valid;
  logic [7:0] spi_rx_byte;
  logic       buf_write_en;
  logic [9:0] buf_write_addr;
  logic [7:0] buf_data_in;
  logic       buf_clear;
  logic       buf_full;
  logic       bnn_start;
  logic       bnn_result_ready;
  logic [3:0] bnn_result_out;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  spi_byte_valid, spi_rx_byte, buf_full, bnn_result_ready,
           bnn_result_out, tx_ready,
    output buf_write_en, buf_write_addr, buf_data_in, buf_clear, bnn_start,
           tx_byte, tx_valid
  );

  modport slave (
    output spi_byte_valid, spi_rx_byte, buf_full, bnn_result_ready,
           bnn_result_out, tx_ready,
    input  buf_write_en, buf_write_addr, buf_data_in, buf_clear, bnn_start,
           tx_byte, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/image_capture_controller_timeout_counter.sv
// ----------------------------------------------------------------------------
// ctrl_timeout_counter: 32-bit idle counter, hit once LIMIT cycles have elapsed
// Rev 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ctrl_timeout_counter #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (clear) begin
      count <= 32'd0;
    end else if (enable && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

  // The cycle holding LIMIT-1 is the LIMIT-th idle cycle
  assign hit = enable && (count >= (LIMIT - 32'd1));

endmodule

`default_nettype wire

// File: rtl/image_capture_controller.sv
// ----------------------------------------------------------------------------
// image_capture_controller: SPI command decode, image write, BNN run, reply
// Optional IMG_CTRL_STATS_EN adds frame_count / dropped_count.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module image_capture_controller
  import img_ctrl_pkg::*;
#(
  parameter int          NUM_BYTES      = DEF_NUM_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_START      = DEF_CMD_START,
  parameter logic [7:0]  CMD_CLEAR      = DEF_CMD_CLEAR
) (
  input  logic        clk,
  input  logic        rst_n,
  image_capture_controller_if.master bus,
  output logic [2:0]  fsm_state,
  output logic        busy,
  output logic        err_timeout
`ifdef IMG_CTRL_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] dropped_count
`endif
);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_RX_IMG    = ST_RX_IMG;
  localparam logic [2:0] S_START_BNN = ST_START_BNN;
  localparam logic [2:0] S_WAIT_BNN  = ST_WAIT_BNN;
  localparam logic [2:0] S_SEND_RES  = ST_SEND_RES;
  localparam logic [2:0] S_CLEAR     = ST_CLEAR;
  localparam logic [2:0] S_ERROR     = ST_ERROR;
  localparam logic [9:0] LAST_IDX    = 10'(NUM_BYTES - 1);

  logic [2:0] state, state_next;
  logic [9:0] byte_cnt;
  logic       accept;
  logic       drop;
  logic       tm_clear, tm_enable, tm_hit;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] tx_byte_r;
  logic       err_r;
  logic       unused_buf_full;

  // buf_full is advisory only; a frame starts regardless of its value
  assign unused_buf_full = bus.buf_full;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.spi_byte_valid) begin
          if (bus.spi_rx_byte == CMD_START)      state_next = S_RX_IMG;
          else if (bus.spi_rx_byte == CMD_CLEAR) state_next = S_CLEAR;
        end
      end
      S_RX_IMG: begin
        if (bus.spi_byte_valid) begin
          accept = 1'b1;
          if (byte_cnt == LAST_IDX) state_next = S_START_BNN;
        end else if (tm_hit) begin
          state_next = S_ERROR;
        end
      end
      S_START_BNN: state_next = S_WAIT_BNN;
      S_WAIT_BNN: begin
        if (bus.bnn_result_ready) state_next = S_SEND_RES;
        else if (tm_hit)          state_next = S_ERROR;
      end
      S_SEND_RES: if (bus.tx_ready) state_next = S_IDLE;
      S_CLEAR:    state_next = S_IDLE;
      S_ERROR:    if (bus.tx_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign drop      = bus.spi_byte_valid && is_drop_state(state);
  assign tm_enable = (state == S_RX_IMG) || (state == S_WAIT_BNN);
  assign tm_clear  = (state_next != state) || accept;

  ctrl_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tm_clear),
    .enable (tm_enable),
    .hit    (tm_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= 10'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 10'd0;
      wr_data   <= 8'd0;
      tx_byte_r <= 8'd0;
      err_r     <= 1'b0;
    end else begin
      state <= state_next;
      wr_en <= accept;
      if (accept) begin
        wr_addr  <= byte_cnt;
        wr_data  <= bus.spi_rx_byte;
        byte_cnt <= byte_cnt + 10'd1;
      end
      if ((state == S_IDLE) && (state_next == S_RX_IMG)) begin
        byte_cnt <= 10'd0;
        err_r    <= 1'b0;
      end
      if ((state == S_WAIT_BNN) && bus.bnn_result_ready) begin
        tx_byte_r <= {RESULT_TAG, bus.bnn_result_out};
      end else if ((state_next == S_ERROR) && (state != S_ERROR)) begin
        tx_byte_r <= ERR_BYTE;
        err_r     <= 1'b1;
      end
    end
  end

`ifdef IMG_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count   <= 16'd0;
      dropped_count <= 16'd0;
    end else begin
      if ((state == S_SEND_RES) && bus.tx_ready && (frame_count != 16'hFFFF))
        frame_count <= frame_count + 16'd1;
      if (drop && (dropped_count != 16'hFFFF))
        dropped_count <= dropped_count + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign bus.buf_write_en   = wr_en;
  assign bus.buf_write_addr = wr_addr;
  assign bus.buf_data_in    = wr_data;
  assign bus.buf_clear      = (state == S_CLEAR);
  assign bus.bnn_start      = (state == S_START_BNN);
  assign bus.tx_byte        = tx_byte_r;
  assign bus.tx_valid       = (state == S_SEND_RES) || (state == S_ERROR);
  assign fsm_state          = state;
  assign busy               = (state != S_IDLE);
  assign err_timeout        = err_r;

endmodule

`default_nettype wire
